qnigma_rtr_sol: RTL

Router Solicitation transmit controller: the sending side of router discovery, paired with the Router Advertisement processing block that drives rtr_det. While the link is enabled and no router is detected, it waits a bounded random delay, then requests up to MAX_SOL Router Solicitations spaced SOL_INTERVAL_S apart through the TX arbiter handshake. After the last one it backs off. It supplies the per-packet metadata (destination IP/MAC, source IP, SLLA option flag) to the ICMP packet builder.

---
 rtl/qnigma_rtr_sol.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/qnigma_rtr_sol.sv
// Router Solicitation transmit controller: waits a random delay, then requests a
// bounded burst of RS packets from the TX arbiter and backs off if no router answers.
module qnigma_rtr_sol #(
    parameter int MAX_SOL        = 3,
    parameter int SOL_INTERVAL_S = 4,
    parameter int MAX_DELAY_MS   = 1000,
    parameter int RETRY_S        = 60
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick_ms,
    input  logic         tick_s,
    input  logic         en,
    input  logic         rtr_det,
    input  logic [9:0]   rnd,
    input  logic [127:0] lla,
    input  logic         lla_vld,
    output logic         tx_req,
    input  logic         tx_ack,
    output logic [127:0] tx_ip_dst,
    output logic [47:0]  tx_mac_dst,
    output logic [127:0] tx_ip_src,
    output logic         tx_opt_slla,
    output logic [1:0]   sol_cnt,
    output logic         sol_fail
);

    localparam logic [9:0]  DELAY_MAX = 10'(MAX_DELAY_MS - 1);
    localparam logic [15:0] SOL_INT   = 16'(SOL_INTERVAL_S);
    localparam logic [15:0] RETRY     = 16'(RETRY_S);
    localparam logic [1:0]  SOL_LAST  = 2'(MAX_SOL);

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        REQ,
        WAIT,
        FAIL
    } state_t;

    state_t         state_q, state_d;
    logic [9:0]     delay_ms_q, delay_ms_d;
    logic [15:0]    interval_s_q, interval_s_d;
    logic [15:0]    backoff_s_q, backoff_s_d;
    logic [1:0]     sol_cnt_q, sol_cnt_d;
    logic           sol_fail_q, sol_fail_d;
    logic           tx_req_q, tx_req_d;
    logic [127:0]   tx_ip_src_q, tx_ip_src_d;
    logic           tx_opt_slla_q, tx_opt_slla_d;
    logic           leave;

    assign leave = !en || rtr_det;

    always_comb begin
        state_d       = state_q;
        delay_ms_d    = delay_ms_q;
        interval_s_d  = interval_s_q;
        backoff_s_d   = backoff_s_q;
        sol_cnt_d     = sol_cnt_q;
        sol_fail_d    = sol_fail_q;
        tx_req_d      = tx_req_q;
        tx_ip_src_d   = tx_ip_src_q;
        tx_opt_slla_d = tx_opt_slla_q;

        case (state_q)
            IDLE: begin
                if (en && !rtr_det) begin
                    state_d    = DELAY;
                    delay_ms_d = (rnd > DELAY_MAX) ? DELAY_MAX : rnd;
                    sol_cnt_d  = '0;
                    sol_fail_d = 1'b0;
                end else if (!en) begin
                    sol_cnt_d  = '0;
                    sol_fail_d = 1'b0;
                end
            end
            DELAY: begin
                if (leave) begin
                    state_d    = IDLE;
                    sol_cnt_d  = '0;
                    sol_fail_d = 1'b0;
                end else if (delay_ms_q == '0) begin
                    state_d       = REQ;
                    tx_req_d      = 1'b1;
                    tx_ip_src_d   = lla_vld ? lla : '0;
                    tx_opt_slla_d = lla_vld;
                end else if (tick_ms) begin
                    delay_ms_d = delay_ms_q - 10'd1;
                end
            end
            REQ: begin
                // An ack coinciding with an abort still counts the packet as sent.
                if (leave) begin
                    state_d  = IDLE;
                    tx_req_d = 1'b0;
                    if (tx_ack) begin
                        sol_cnt_d = sol_cnt_q + 2'd1;
                    end else if (!en) begin
                        sol_cnt_d  = '0;
                        sol_fail_d = 1'b0;
                    end
                end else if (tx_ack) begin
                    state_d      = WAIT;
                    tx_req_d     = 1'b0;
                    sol_cnt_d    = sol_cnt_q + 2'd1;
                    interval_s_d = SOL_INT;
                end
            end
            WAIT: begin
                if (leave) begin
                    state_d    = IDLE;
                    sol_cnt_d  = '0;
                    sol_fail_d = 1'b0;
                end else if (interval_s_q == '0) begin
                    if (sol_cnt_q == SOL_LAST) begin
                        state_d     = FAIL;
                        sol_fail_d  = 1'b1;
                        backoff_s_d = RETRY;
                    end else begin
                        state_d       = REQ;
                        tx_req_d      = 1'b1;
                        tx_ip_src_d   = lla_vld ? lla : '0;
                        tx_opt_slla_d = lla_vld;
                    end
                end else if (tick_s) begin
                    interval_s_d = interval_s_q - 16'd1;
                end
            end
            FAIL: begin
                if (leave) begin
                    state_d    = IDLE;
                    sol_cnt_d  = '0;
                    sol_fail_d = 1'b0;
                end else if (backoff_s_q == '0) begin
                    state_d = IDLE;
                end else if (tick_s) begin
                    backoff_s_d = backoff_s_q - 16'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                tx_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            delay_ms_q    <= '0;
            interval_s_q  <= '0;
            backoff_s_q   <= '0;
            sol_cnt_q     <= '0;
            sol_fail_q    <= 1'b0;
            tx_req_q      <= 1'b0;
            tx_ip_src_q   <= '0;
            tx_opt_slla_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            delay_ms_q    <= delay_ms_d;
            interval_s_q  <= interval_s_d;
            backoff_s_q   <= backoff_s_d;
            sol_cnt_q     <= sol_cnt_d;
            sol_fail_q    <= sol_fail_d;
            tx_req_q      <= tx_req_d;
            tx_ip_src_q   <= tx_ip_src_d;
            tx_opt_slla_q <= tx_opt_slla_d;
        end
    end

    assign tx_req      = tx_req_q;
    assign tx_ip_src   = tx_ip_src_q;
    assign tx_opt_slla = tx_opt_slla_q;
    assign sol_cnt     = sol_cnt_q;
    assign sol_fail    = sol_fail_q;
    assign tx_ip_dst   = 128'hff02_0000_0000_0000_0000_0000_0000_0002;
    assign tx_mac_dst  = 48'h3333_0000_0002;

endmodule
